vga_scan_ctrl: RTL

Parametrised successor to the fixed 640x480 VGA controller/framebuffer pair.
- Generates H/V timing from parameters.
- Produces an incrementally computed linear framebuffer read address; no multiplier or shift-add address math.
- Aligns sync and valid with a framebuffer of configurable read latency.
- Adds a 2x pixel-replication mode: a 320x240 buffer drives the 640x480 raster.
- Sits between the SoC framebuffer RAM and the VGA pins.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_scan_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA scan types: default 640x480@60 timing, rgb pixel struct and
// raster region classification used by the scan controller.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_COLOR_W  = 8;
   localparam int VGA_ADDR_W   = 19;

   typedef struct packed {
      logic [VGA_COLOR_W-1:0] r;
      logic [VGA_COLOR_W-1:0] g;
      logic [VGA_COLOR_W-1:0] b;
   } rgb_t;

   typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_e;

   // Regions are laid out active, front porch, sync, back porch along each axis.
   function automatic region_e region_of(input int cnt, input int act_len,
                                         input int fp_len, input int sync_len);
      if (cnt < act_len)                     return ACTIVE;
      if (cnt < act_len + fp_len)            return FP;
      if (cnt < act_len + fp_len + sync_len) return SYNC;
      return BP;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to INIT.
// DEPTH of 0 degenerates to a wire.
module vga_delay_line
   import vga_pkg::*;
#(
   parameter int               DEPTH = 1,
   parameter int               WIDTH = 1,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_bypass;
         assign unused_bypass = clk ^ reset;
         assign q = d;
      end else begin : g_shift
         logic [WIDTH-1:0] sr_p [DEPTH];

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < DEPTH; i++) sr_p[i] <= INIT;
            end else begin
               sr_p[0] <= d;
               for (int i = 1; i < DEPTH; i++) sr_p[i] <= sr_p[i-1];
            end
         end

         assign q = sr_p[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_scan_ctrl.sv
// Parametrised VGA raster generator with incremental framebuffer addressing,
// 2x pixel replication and latency-matched outputs. Optional colour-bar
// generator is built when VGA_TEST_PATTERN_EN is defined (adds port tp_en).
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int RD_LAT   = 1,
   parameter int ADDR_W   = VGA_ADDR_W,
   parameter int COLOR_W  = VGA_COLOR_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 scale_x2,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                 tp_en,
`endif
   output logic                 fb_rd,
   output logic [ADDR_W-1:0]    fb_addr,
   input  logic [3*COLOR_W-1:0] fb_data,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 valid,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b,
   output logic                 frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HC_W    = $clog2(H_TOTAL);
   localparam int VC_W    = $clog2(V_TOTAL);
   localparam int PIX_W   = 3 * COLOR_W;

   localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0] H_ACT_LAST = HC_W'(H_ACTIVE - 1);
   localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
   localparam logic [3:0]      BUN_IDLE   = {~HS_POL, ~VS_POL, 1'b0, 1'b0};

   logic [HC_W-1:0]   h_cnt;
   logic [VC_W-1:0]   v_cnt;
   logic [ADDR_W-1:0] line_base;
   logic              mode_q;

   region_e           h_reg;
   region_e           v_reg;
   logic              frame_org;
   logic              mode_eff;
   logic              vld_p0;
   logic              hs_p0;
   logic              vs_p0;
   logic              fs_p0;
   logic [3:0]        bun_p0;
   logic [3:0]        bun_p1;
   logic [PIX_W-1:0]  pix_p1;

   // ---- stage 0: raster counters, region decode, read request ----
   always_comb begin
      h_reg     = region_of(int'(h_cnt), H_ACTIVE, H_FP, H_SYNC);
      v_reg     = region_of(int'(v_cnt), V_ACTIVE, V_FP, V_SYNC);
      frame_org = (h_cnt == '0) && (v_cnt == '0);
      mode_eff  = frame_org ? scale_x2 : mode_q;
      vld_p0    = en && (h_reg == ACTIVE) && (v_reg == ACTIVE);
      hs_p0     = (en && (h_reg == SYNC)) ? HS_POL : ~HS_POL;
      vs_p0     = (en && (v_reg == SYNC)) ? VS_POL : ~VS_POL;
      fs_p0     = en && frame_org;
   end

`ifdef VGA_TEST_PATTERN_EN
   assign fb_rd = vld_p0 & ~tp_en & reset;
`else
   assign fb_rd = vld_p0 & reset;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         fb_addr   <= '0;
         line_base <= '0;
         mode_q    <= 1'b0;
      end else if (en) begin
         h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
         if (h_cnt == H_LAST)
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         if (frame_org)
            mode_q <= scale_x2;

         if ((h_cnt == H_LAST) && (v_cnt == V_LAST)) begin
            fb_addr   <= '0;
            line_base <= '0;
         end else if (vld_p0) begin
            if (!mode_eff) begin
               fb_addr <= fb_addr + ADDR_W'(1);
            end else if (h_cnt == H_ACT_LAST) begin
               // Even lines replay the same source row; odd lines move on to the next.
               if (v_cnt[0]) begin
                  fb_addr   <= fb_addr + ADDR_W'(1);
                  line_base <= fb_addr + ADDR_W'(1);
               end else begin
                  fb_addr <= line_base;
               end
            end else if (h_cnt[0]) begin
               fb_addr <= fb_addr + ADDR_W'(1);
            end
         end
      end
   end

   assign bun_p0 = {hs_p0, vs_p0, vld_p0, fs_p0};

   // ---- stage 1: control delayed by the framebuffer read latency ----
   vga_delay_line #(
      .DEPTH (RD_LAT),
      .WIDTH (4),
      .INIT  (BUN_IDLE)
   ) u_bun_dly (
      .clk   (clk),
      .reset (reset),
      .d     (bun_p0),
      .q     (bun_p1)
   );

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0]     bar_p0;
   logic [PIX_W:0] tp_p0;
   logic [PIX_W:0] tp_p1;

   always_comb begin
      bar_p0 = '0;
      for (int k = 1; k < 8; k++)
         if ({h_cnt, 3'b000} >= (HC_W+3)'(k * H_ACTIVE)) bar_p0 = 3'(k);
   end

   assign tp_p0 = {tp_en,
                   {COLOR_W{~bar_p0[1]}},
                   {COLOR_W{~bar_p0[2]}},
                   {COLOR_W{~bar_p0[0]}}};

   vga_delay_line #(
      .DEPTH (RD_LAT),
      .WIDTH (PIX_W + 1),
      .INIT  ('0)
   ) u_tp_dly (
      .clk   (clk),
      .reset (reset),
      .d     (tp_p0),
      .q     (tp_p1)
   );

   assign pix_p1 = tp_p1[PIX_W] ? tp_p1[PIX_W-1:0] : fb_data;
`else
   assign pix_p1 = fb_data;
`endif

   // ---- stage 2: registered pins ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         valid       <= 1'b0;
         frame_start <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
      end else begin
         {hsync, vsync, valid, frame_start} <= bun_p1;
         if (bun_p1[1])
            {vga_r, vga_g, vga_b} <= pix_p1;
         else
            {vga_r, vga_g, vga_b} <= '0;
      end
   end

endmodule
